// File: rtl/skolem_pkg.sv
// Shared types and helpers for the sequential arithmetic-shift Skolem
// witness generator.
package skolem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHL,
        SHR,
        CMP,
        DONE
    } skolem_state_e;

    // min(s, lim) evaluated at full width so large s never aliases
    function automatic longint unsigned clamp_shift(
        input longint unsigned s,
        input longint unsigned lim
    );
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/bv_shift_step.sv
// One-bit shifter shared by the left-shift and arithmetic-right phases.
// dir = 0 shifts left with zero fill, dir = 1 shifts right replicating MSB.
module bv_shift_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] din,
    input  logic         dir,
    output logic [W-1:0] dout
);

    assign dout = dir ? {din[W-1], din[W-1:1]}
                      : {din[W-2:0], 1'b0};

endmodule

// File: rtl/skolem_bvashr_seq.sv
// Sequential Skolem witness for x >>a s == t: x = t << min(s, W-1),
// then re-shifted arithmetically and compared against t for the SAT flag.
module skolem_bvashr_seq
    import skolem_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_s,
    input  logic [W-1:0] req_t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic         out_sat,
    output logic         busy
);

    localparam int CW = $clog2(W);

    skolem_state_e state;
    skolem_state_e nxt;

    logic [CW-1:0] cnt;
    logic [CW-1:0] k_q;
    logic [CW-1:0] k_in;
    logic [W-1:0]  x_q;
    logic [W-1:0]  t_q;
    logic [W-1:0]  wit_q;
    logic          sat_q;
    logic [W-1:0]  x_sh;
    logic          accept;
    logic          last;

    assign k_in   = CW'(clamp_shift(64'(req_s), 64'(W - 1)));
    assign accept = req_valid & req_ready;
    assign last   = (cnt == CW'(1));

    bv_shift_step #(
        .W(W)
    ) u_step (
        .din (x_q),
        .dir (state == SHR),
        .dout(x_sh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nxt = (k_in != '0) ? SHL : CMP;
                end
            end
            SHL: begin
                if (last) nxt = SHR;
            end
            SHR: begin
                if (last) nxt = CMP;
            end
            CMP: begin
                nxt = DONE;
            end
            DONE: begin
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            k_q   <= '0;
            x_q   <= '0;
            t_q   <= '0;
            wit_q <= '0;
            sat_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        t_q <= req_t;
                        x_q <= req_t;
                        cnt <= k_in;
                        k_q <= k_in;
                    end
                end
                SHL: begin
                    x_q <= x_sh;
                    if (last) begin
                        wit_q <= x_sh;
                        cnt   <= k_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SHR: begin
                    x_q <= x_sh;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                CMP: begin
                    sat_q <= (x_q == t_q);
                    if (k_q == '0) wit_q <= t_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        out_x     = (state == DONE) ? wit_q : '0;
        out_sat   = (state == DONE) & sat_q;
    end

endmodule

// File: tb/tb_skolem_bvashr_seq.sv
// Randomized and directed bench for skolem_bvashr_seq at W = 4.
module tb_skolem_bvashr_seq;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_s;
    logic [3:0] req_t;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x;
    logic       out_sat;
    logic       busy;

    int checks = 0;
    int errors = 0;

    skolem_bvashr_seq #(
        .W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_s    (req_s),
        .req_t    (req_t),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: witness is t*2^k mod 16; SAT iff top k+1 bits of t agree
    function automatic void model(
        input  int         s,
        input  int         t,
        output int         k,
        output logic [3:0] x,
        output logic       sat
    );
        k   = (s > 3) ? 3 : s;
        x   = 4'((t * (1 << k)) % 16);
        sat = 1'b1;
        for (int i = 0; i <= k; i++) begin
            if (((t >> (3 - i)) & 1) != ((t >> 3) & 1)) sat = 1'b0;
        end
    endfunction

    // Presents one request and waits for out_valid; returns edges counted
    task automatic issue(input logic [3:0] s, input logic [3:0] t,
                         output int lat);
        req_s     = s;
        req_t     = t;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_s     = 4'($urandom);
        req_t     = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_x !== 4'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b x=%b sat=%b need 1 0 0 0000 0",
                     req_ready, out_valid, busy, out_x, out_sat);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [3:0] ss [5] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd9};
        logic [3:0] ts [5] = '{4'b1010, 4'b1110, 4'b0100, 4'b1111, 4'b0111};
        logic [3:0] xs [5] = '{4'b1010, 4'b1100, 4'b0000, 4'b1000, 4'b1000};
        logic       sats [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        int         lats [5] = '{1, 3, 5, 7, 7};
        int         lat;
        for (int i = 0; i < 5; i++) begin
            issue(ss[i], ts[i], lat);
            checks++;
            if (lat != lats[i] || out_x !== xs[i] || out_sat !== sats[i]) begin
                errors++;
                $display("FAIL directed[%0d]: lat=%0d x=%b sat=%b need lat=%0d x=%b sat=%b",
                         i, lat, out_x, out_sat, lats[i], xs[i], sats[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        int         s, t, k, lat, hold;
        logic [3:0] ex;
        logic       esat;
        for (int n = 0; n < 40; n++) begin
            s = $urandom_range(0, 15);
            t = $urandom_range(0, 15);
            model(s, t, k, ex, esat);
            issue(4'(s), 4'(t), lat);
            checks++;
            if (lat != 2 * k + 1 || out_x !== ex || out_sat !== esat) begin
                errors++;
                $display("FAIL random s=%0d t=%b: lat=%0d x=%b sat=%b need lat=%0d x=%b sat=%b",
                         s, 4'(t), lat, out_x, out_sat, 2 * k + 1, ex, esat);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b1 || out_x !== ex || out_sat !== esat ||
                    req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL random_hold: vld=%b x=%b sat=%b rdy=%b need 1 %b %b 0",
                             out_valid, out_x, out_sat, req_ready, ex, esat);
                end
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(4'd1, 4'b1110, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_x !== 4'b1100 || out_sat !== 1'b1 ||
                req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure[%0d]: vld=%b x=%b sat=%b rdy=%b busy=%b need 1 1100 1 0 1",
                         c, out_valid, out_x, out_sat, req_ready, busy);
            end
        end
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_s     = 4'd0;
        req_t     = 4'b0101;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_bubble: rdy=%b busy=%b vld=%b need 1 0 0",
                     req_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int seen;
        req_s     = 4'd3;
        req_t     = 4'b1011;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: busy=%b need 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_x !== 4'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: rdy=%b vld=%b busy=%b x=%b sat=%b need 1 0 0 0000 0",
                     req_ready, out_valid, busy, out_x, out_sat);
        end
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midop_no_result: active cycles=%0d need 0", seen);
        end
        issue(4'd1, 4'b0000, lat);
        checks++;
        if (lat != 3 || out_x !== 4'b0000 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: lat=%0d x=%b sat=%b need 3 0000 1",
                     lat, out_x, out_sat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int         s, t, k, cyc, got;
        logic [3:0] ex;
        logic       esat;
        logic       overlap;
        for (int n = 0; n < 8; n++) begin
            s = $urandom_range(0, 5);
            t = $urandom_range(0, 15);
            model(s, t, k, ex, esat);
            req_s     = 4'(s);
            req_t     = 4'(t);
            req_valid = 1'b1;
            out_ready = 1'b1;
            overlap   = 1'b0;
            got       = 0;
            cyc       = 0;
            while (!req_ready && cyc < 50) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 50) begin
                if (out_valid && req_ready) overlap = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
            end
            if (out_valid && req_ready) overlap = 1'b1;
            if (out_valid) got = 1;
            checks++;
            if (got != 1 || overlap || out_x !== ex || out_sat !== esat ||
                cyc != 2 * k + 1) begin
                errors++;
                $display("FAIL b2b s=%0d t=%b: got=%0d ovl=%b lat=%0d x=%b sat=%b need lat=%0d x=%b sat=%b",
                         s, 4'(t), got, overlap, cyc, out_x, out_sat,
                         2 * k + 1, ex, esat);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0;
        req_s     = 4'd0;
        req_t     = 4'd0;
        out_ready = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
